// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_ADDR_W      = 8;
  localparam int FETCH_DATA_W      = 8;
  localparam int FETCH_RESET_PC    = 0;
  localparam int FETCH_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: asynchronous reset, parallel load, increment with natural wrap.
module pc_reg #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= ADDR_W'(RESET_PC);
    else if (load) q <= d;
    else if (inc)  q <= q + ADDR_W'(1);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC load, one-byte req/ready read, instruction latch.
// Optional wait-state abort is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int DATA_W   = FETCH_DATA_W,
  parameter int RESET_PC = FETCH_RESET_PC
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = FETCH_TIMEOUT_CYC
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              load,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              err
);

  fetch_state_t state, next_state;
  logic         pc_load;
  logic         pc_inc;
  logic         instr_en;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .inc  (pc_inc),
    .d    (addr_in),
    .q    (pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             abort;

  // Abort on the cycle that would be the TIMEOUT_CYC-th consecutive wait state.
  assign abort = (state == REQ) && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 wait_cnt <= '0;
    else if (state != REQ)   wait_cnt <= '0;
    else if (!mem_ready)     wait_cnt <= wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= abort;
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    instr_en   = 1'b0;
    case (state)
      IDLE: begin
        // Loading on the same edge as the start makes the fetch use addr_in.
        pc_load = load;
        if (start) next_state = REQ;
      end
      REQ: begin
        if (mem_ready) begin
          instr_en   = 1'b1;
          pc_inc     = 1'b1;
          next_state = DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (abort) begin
          next_state = IDLE;
        end
`endif
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           instr <= '0;
    else if (instr_en) instr <= mem_data;
  end

  assign mem_addr    = pc;
  assign mem_req     = (state == REQ);
  assign instr_valid = (state == DONE);
  assign busy        = (state != IDLE);

endmodule
